rab_range_invalidator: RTL and testbench

//  Range-based TLB invalidation engine for one RAB port with L2 TLB. Takes an

---
 rtl/rab_range_invalidator.sv | 189 ++++++++++++++++++
 tb/tb_rab_range_invalidator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rab_range_invalidator.sv
// Range TLB invalidation walker for one RAB port: clears L2 tag entries
// whose VPN lies in an inclusive VA range and broadcasts the range to L1.
//
// Ports:
//   Clk_CI/Rst_RI            clock, async active-high reset
//   InvValid_SI/InvReady_SO  request handshake
//   InvAddrStart_DI/End_DI   inclusive VA range
//   Stall_SI                 freezes the walk (tag RAM in use elsewhere)
//   Busy_SO/Done_SO          walk status, 1-cycle completion pulse
//   InvCnt_DO                entries cleared by last request (saturating)
//   L1Inv*                   1-cycle L1 range-invalidate broadcast
//   Tag*                     L2 tag RAM port (1-cycle read latency)
module rab_range_invalidator #(
  parameter int AW            = 32,
  parameter int PAGE_BITS     = 12,
  parameter int N_SETS        = 32,
  parameter int N_SET_ENTRIES = 32,
  parameter int CNT_W         = 16,
  localparam int VW = AW - PAGE_BITS,
  localparam int TW = VW + 4,
  localparam int SB = $clog2(N_SETS),
  localparam int EB = $clog2(N_SET_ENTRIES),
  localparam int AB = SB + EB
) (
  input  logic             Clk_CI,
  input  logic             Rst_RI,
  input  logic             InvValid_SI,
  output logic             InvReady_SO,
  input  logic [AW-1:0]    InvAddrStart_DI,
  input  logic [AW-1:0]    InvAddrEnd_DI,
  input  logic             Stall_SI,
  output logic             Busy_SO,
  output logic             Done_SO,
  output logic [CNT_W-1:0] InvCnt_DO,
  output logic             L1InvValid_SO,
  output logic [AW-1:0]    L1InvStart_DO,
  output logic [AW-1:0]    L1InvEnd_DO,
  output logic [AB-1:0]    TagAddr_DO,
  output logic             TagRdEn_SO,
  input  logic [TW-1:0]    TagRdData_DI,
  output logic             TagWrEn_SO,
  output logic [TW-1:0]    TagWrData_DO
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CMP, S_WR, S_DONE
  } state_e;

  localparam logic [VW:0] NSETS_SPAN = (VW+1)'(N_SETS);
  localparam logic [SB:0] NSETS_CNT  = (SB+1)'(N_SETS);
  localparam logic [EB-1:0] LAST_ENT = EB'(N_SET_ENTRIES - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    start_q, start_d;
  logic [AW-1:0]    end_q, end_d;
  logic [VW-1:0]    sv_q, sv_d;
  logic [VW-1:0]    ev_q, ev_d;
  logic [SB:0]      n_sets_q, n_sets_d;
  logic [SB:0]      sets_done_q, sets_done_d;
  logic [SB-1:0]    set_q, set_d;
  logic [EB-1:0]    entry_q, entry_d;
  logic [TW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             l1_pend_q, l1_pend_d;

  logic [VW-1:0] sv_in, ev_in, tag_vpn;
  logic [VW:0]   span;
  logic          hit, adv;

  assign sv_in   = InvAddrStart_DI[AW-1:PAGE_BITS];
  assign ev_in   = InvAddrEnd_DI[AW-1:PAGE_BITS];
  // One extra bit so the full address space (2^VW pages) fits.
  assign span    = {1'b0, ev_in} - {1'b0, sv_in} + 1'b1;
  assign tag_vpn = TagRdData_DI[TW-1:4];
  assign hit     = TagRdData_DI[0] &&
                   (tag_vpn >= sv_q) && (tag_vpn <= ev_q);

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    end_d       = end_q;
    sv_d        = sv_q;
    ev_d        = ev_q;
    n_sets_d    = n_sets_q;
    sets_done_d = sets_done_q;
    set_d       = set_q;
    entry_d     = entry_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    l1_pend_d   = l1_pend_q;
    adv         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (InvValid_SI) begin
          start_d = InvAddrStart_DI;
          end_d   = InvAddrEnd_DI;
          sv_d    = sv_in;
          ev_d    = ev_in;
          cnt_d   = '0;
          if (sv_in > ev_in) begin
            state_d = S_DONE;
          end else begin
            n_sets_d    = (span >= NSETS_SPAN) ?
                          NSETS_CNT : span[SB:0];
            set_d       = sv_in[SB-1:0];
            entry_d     = '0;
            sets_done_d = '0;
            l1_pend_d   = 1'b1;
            state_d     = S_RD;
          end
        end
      end
      S_RD: begin
        // Broadcast fires on the first RD cycle even if stalled.
        l1_pend_d = 1'b0;
        if (!Stall_SI) state_d = S_CMP;
      end
      S_CMP: begin
        data_d = TagRdData_DI;
        if (hit) state_d = S_WR;
        else     adv     = 1'b1;
      end
      S_WR: begin
        if (!Stall_SI) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          adv = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      entry_d = entry_q + 1'b1;
      state_d = S_RD;
      if (entry_q == LAST_ENT) begin
        entry_d     = '0;
        set_d       = set_q + 1'b1;
        sets_done_d = sets_done_q + 1'b1;
        if (sets_done_d == n_sets_q) state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q     <= S_IDLE;
      start_q     <= '0;
      end_q       <= '0;
      sv_q        <= '0;
      ev_q        <= '0;
      n_sets_q    <= '0;
      sets_done_q <= '0;
      set_q       <= '0;
      entry_q     <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      l1_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      end_q       <= end_d;
      sv_q        <= sv_d;
      ev_q        <= ev_d;
      n_sets_q    <= n_sets_d;
      sets_done_q <= sets_done_d;
      set_q       <= set_d;
      entry_q     <= entry_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      l1_pend_q   <= l1_pend_d;
    end
  end

  assign InvReady_SO   = (state_q == S_IDLE);
  assign Busy_SO       = (state_q == S_RD) || (state_q == S_CMP) ||
                         (state_q == S_WR);
  assign Done_SO       = (state_q == S_DONE);
  assign InvCnt_DO     = cnt_q;
  assign L1InvValid_SO = (state_q == S_RD) && l1_pend_q;
  assign L1InvStart_DO = L1InvValid_SO ? start_q : '0;
  assign L1InvEnd_DO   = L1InvValid_SO ? end_q : '0;
  assign TagAddr_DO    = {set_q, entry_q};
  assign TagRdEn_SO    = (state_q == S_RD) && !Stall_SI;
  assign TagWrEn_SO    = (state_q == S_WR) && !Stall_SI;
  assign TagWrData_DO  = {data_q[TW-1:1], 1'b0};

endmodule

// File: tb/tb_rab_range_invalidator.sv
// Directed bench for rab_range_invalidator with a behavioural tag RAM.
// Covers single-set, wrapping, full-range, empty-range, stall and reset.
module tb_rab_range_invalidator;

  localparam int TW  = 24;
  localparam int NE  = 1024;
  localparam int LIM = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] a_start = '0;
  logic [31:0] a_end = '0;
  logic        stall = 1'b0;
  logic        busy, done, l1v, rden, wren;
  logic [15:0] cnt;
  logic [31:0] l1s, l1e;
  logic [9:0]  addr;
  logic [TW-1:0] rdata = '0;
  logic [TW-1:0] wdata;

  logic [TW-1:0] mem [NE];
  int rd_cnt [NE];
  logic [9:0] rd_q [$];
  int wr_n, l1_n, both_n, stall_n;
  logic [31:0] l1s_cap, l1e_cap;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rab_range_invalidator dut (
    .Clk_CI(clk), .Rst_RI(rst),
    .InvValid_SI(valid), .InvReady_SO(ready),
    .InvAddrStart_DI(a_start), .InvAddrEnd_DI(a_end),
    .Stall_SI(stall), .Busy_SO(busy), .Done_SO(done),
    .InvCnt_DO(cnt), .L1InvValid_SO(l1v),
    .L1InvStart_DO(l1s), .L1InvEnd_DO(l1e),
    .TagAddr_DO(addr), .TagRdEn_SO(rden),
    .TagRdData_DI(rdata), .TagWrEn_SO(wren),
    .TagWrData_DO(wdata)
  );

  always @(posedge clk) begin
    if (rden) rdata <= mem[addr];
    if (wren) mem[addr] = wdata;
  end

  always @(negedge clk) begin
    if (rden) begin
      rd_q.push_back(addr);
      rd_cnt[addr] = rd_cnt[addr] + 1;
    end
    if (wren) wr_n = wr_n + 1;
    if (l1v) begin
      l1_n = l1_n + 1;
      l1s_cap = l1s;
      l1e_cap = l1e;
    end
    if (rden && wren) both_n = both_n + 1;
    if (stall && (rden || wren)) stall_n = stall_n + 1;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_mem();
    for (int i = 0; i < NE; i++) mem[i] = '0;
  endtask

  function automatic logic [TW-1:0] tw(input int vpn, input bit v);
    return {vpn[19:0], 3'b000, v};
  endfunction

  task automatic clr_mon();
    for (int i = 0; i < NE; i++) rd_cnt[i] = 0;
    rd_q.delete();
    wr_n = 0; l1_n = 0; both_n = 0; stall_n = 0;
    l1s_cap = '0; l1e_cap = '0;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_rdy"}, 64'(ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_cnt"}, 64'(cnt), 64'd0);
    chk({tag, "_l1"}, 64'(l1v), 64'd0);
    chk({tag, "_en"}, 64'({rden, wren}), 64'd0);
    chk({tag, "_addr"}, 64'(addr), 64'd0);
    chk({tag, "_wd"}, 64'(wdata), 64'd0);
  endtask

  // Returns the cycle (accept cycle = 0) on which Done is seen,
  // or -1 if reset was pulsed at cycle rst_at.
  task automatic run_req(input logic [31:0] s, input logic [31:0] e,
                         input int sf, input int rst_at,
                         output int lat);
    bit fin;
    lat = -1;
    fin = 0;
    @(negedge clk);
    chk("accept_rdy", 64'(ready), 64'd1);
    valid = 1'b1; a_start = s; a_end = e;
    @(posedge clk);
    #1 valid = 1'b0;
    clr_mon();
    for (int k = 1; k <= LIM && !fin; k++) begin
      stall = (sf > 0) && (k >= sf) && (k < sf + 10);
      if (k == rst_at) begin
        rst = 1'b1;
        #1 reset_chk("midrst");
        fin = 1;
      end else begin
        @(negedge clk);
        if (done) begin
          lat = k;
          fin = 1;
        end else begin
          @(posedge clk);
          #1;
        end
      end
    end
    stall = 1'b0;
    if (!fin) chk("timeout", 64'd0, 64'd1);
  endtask

  task automatic setup_t2();
    clr_mem();
    mem[31*32+5] = tw(31, 1);
    mem[0*32+7]  = tw(32, 1);
    mem[1*32+2]  = tw(33, 1);
    mem[1*32+3]  = tw(1, 1);
    mem[0*32+0]  = tw(32, 0);
    mem[2*32+0]  = tw(34, 1);
  endtask

  task automatic check_t2(input string t);
    chk({t, "_cnt"}, 64'(cnt), 64'd3);
    chk({t, "_wr"}, 64'(wr_n), 64'd3);
    chk({t, "_m31_5"}, 64'(mem[31*32+5]), 64'(tw(31, 0)));
    chk({t, "_m0_7"}, 64'(mem[7]), 64'(tw(32, 0)));
    chk({t, "_m1_2"}, 64'(mem[34]), 64'(tw(33, 0)));
    chk({t, "_m1_3"}, 64'(mem[35]), 64'(tw(1, 1)));
    chk({t, "_m0_0"}, 64'(mem[0]), 64'(tw(32, 0)));
    chk({t, "_m2_0"}, 64'(mem[64]), 64'(tw(34, 1)));
  endtask

  initial begin
    int lat, bad;
    clr_mem();
    clr_mon();
    #1 rst = 1'b1;
    #1 reset_chk("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // T1: single set, one hit
    mem[3*32] = tw(3, 1);
    run_req(32'h3000, 32'h3FFF, 0, 0, lat);
    chk("t1_lat", 64'(lat), 64'd66);
    chk("t1_cnt", 64'(cnt), 64'd1);
    chk("t1_wr", 64'(wr_n), 64'd1);
    chk("t1_mem", 64'(mem[96]), 64'(tw(3, 0)));
    chk("t1_rd", 64'(rd_q.size()), 64'd32);
    bad = 0;
    foreach (rd_q[i]) if (rd_q[i][9:5] != 5'd3) bad++;
    chk("t1_set", 64'(bad), 64'd0);
    chk("t1_l1n", 64'(l1_n), 64'd1);
    chk("t1_l1s", 64'(l1s_cap), 64'h3000);
    chk("t1_l1e", 64'(l1e_cap), 64'h3FFF);
    chk("t1_both", 64'(both_n), 64'd0);

    // T2: wrap from set 31 to sets 0,1
    setup_t2();
    run_req(32'h1F000, 32'h21FFF, 0, 0, lat);
    chk("t2_lat", 64'(lat), 64'd196);
    chk("t2_rd", 64'(rd_q.size()), 64'd96);
    bad = 0;
    foreach (rd_q[i]) begin
      if (i < 32 && rd_q[i][9:5] != 5'd31) bad++;
      if (i >= 32 && i < 64 && rd_q[i][9:5] != 5'd0) bad++;
      if (i >= 64 && rd_q[i][9:5] != 5'd1) bad++;
    end
    chk("t2_order", 64'(bad), 64'd0);
    check_t2("t2");

    // T3: everything valid, full address range
    for (int i = 0; i < NE; i++) mem[i] = tw((i * 37) & 20'hFFFFF, 1);
    run_req(32'h0, 32'hFFFF_FFFF, 0, 0, lat);
    chk("t3_lat", 64'(lat), 64'd3073);
    chk("t3_cnt", 64'(cnt), 64'd1024);
    bad = 0;
    for (int i = 0; i < NE; i++) begin
      if (rd_cnt[i] != 1) bad++;
      if (mem[i][0] != 1'b0) bad++;
    end
    chk("t3_once_clr", 64'(bad), 64'd0);
    chk("t3_both", 64'(both_n), 64'd0);

    // T4: empty range (start page above end page)
    run_req(32'h5000, 32'h4000, 0, 0, lat);
    chk("t4_lat", 64'(lat), 64'd1);
    chk("t4_rd", 64'(rd_q.size()), 64'd0);
    chk("t4_l1", 64'(l1_n), 64'd0);
    chk("t4_cnt", 64'(cnt), 64'd0);

    // T5: T2 again, stalled 10 cycles starting at the first WR
    setup_t2();
    run_req(32'h1F000, 32'h21FFF, 13, 0, lat);
    chk("t5_lat", 64'(lat), 64'd206);
    chk("t5_stall_en", 64'(stall_n), 64'd0);
    chk("t5_l1n", 64'(l1_n), 64'd1);
    check_t2("t5");

    // T6: reset mid-walk, then a fresh request
    for (int i = 0; i < NE; i++) mem[i] = tw(i, 1);
    run_req(32'h0, 32'hFFFF_FFFF, 0, 50, lat);
    chk("t6_abort", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    wr_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_nowr", 64'(wr_n), 64'd0);
    rst = 1'b0;
    clr_mem();
    mem[3*32+9] = tw(3, 1);
    mem[3*32+10] = tw(4, 1);
    run_req(32'h3000, 32'h3FFF, 0, 0, lat);
    chk("t6_lat", 64'(lat), 64'd66);
    chk("t6_cnt", 64'(cnt), 64'd1);
    chk("t6_l1n", 64'(l1_n), 64'd1);
    chk("t6_mem", 64'(mem[105]), 64'(tw(3, 0)));
    chk("t6_keep", 64'(mem[106]), 64'(tw(4, 1)));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
